// File: rtl/motor_step_seq.sv
// Stepper-motor phase sequencer: issues a latched number of phase advances,
// each held for a latched dwell period, with abort and a one-cycle done pulse.
module motor_step_seq #(
  parameter int STEP_W = 8,
  parameter int PER_W  = 16
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_dir,
  input  logic [STEP_W-1:0] i_steps,
  input  logic [PER_W-1:0]  i_period,
  output logic [2:0]        o_motor,
  output logic              o_enable,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_dbg_state
);

  // i_start is a one-cycle request accepted only in IDLE (no backpressure);
  // i_stop is honoured only in RUN. Requests in any other state are dropped.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          phase_q, phase_d;
  logic                dir_q, dir_d;
  logic [STEP_W-1:0]   remaining_q, remaining_d;
  logic [PER_W-1:0]    period_q, period_d;
  logic [PER_W-1:0]    timer_q, timer_d;

  function automatic logic [1:0] next_phase(input logic [1:0] p, input logic fwd);
    return fwd ? p + 2'd1 : p - 2'd1;
  endfunction

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q     <= IDLE;
      phase_q     <= 2'd0;
      dir_q       <= 1'b0;
      remaining_q <= '0;
      period_q    <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      dir_q       <= dir_d;
      remaining_q <= remaining_d;
      period_q    <= period_d;
      timer_q     <= timer_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    dir_d       = dir_q;
    remaining_d = remaining_q;
    period_d    = period_q;
    timer_d     = timer_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          if (i_steps != '0 && i_period != '0) begin
            // The first phase advance happens on acceptance, so RUN opens
            // already presenting the first step's code.
            dir_d       = i_dir;
            period_d    = i_period;
            remaining_d = i_steps - STEP_W'(1);
            timer_d     = '0;
            phase_d     = next_phase(phase_q, i_dir);
            state_d     = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (i_stop) begin
          state_d = DONE;
        end else if (timer_q == period_q - PER_W'(1)) begin
          if (remaining_q != '0) begin
            phase_d     = next_phase(phase_q, dir_q);
            remaining_d = remaining_q - STEP_W'(1);
            timer_d     = '0;
          end else begin
            state_d = DONE;
          end
        end else begin
          timer_d = timer_q + PER_W'(1);
        end
      end
      DONE: begin
        timer_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_motor     = {1'b0, phase_q} + 3'd1;
  assign o_enable    = (state_q == RUN);
  assign o_busy      = (state_q != IDLE);
  assign o_done      = (state_q == DONE);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_motor_step_seq.sv
// Bench for motor_step_seq: a timeline model of each move, checked every cycle,
// plus hand-computed literal checks on the final phase and pulse counts.
module tb_motor_step_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        dir = 1'b0;
  logic [7:0]  steps = '0;
  logic [15:0] period = '0;
  logic [2:0]  o_motor;
  logic        o_enable, o_busy, o_done;
  logic [1:0]  o_dbg_state;

  motor_step_seq #(.STEP_W(8), .PER_W(16)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_start(start), .i_stop(stop), .i_dir(dir),
    .i_steps(steps), .i_period(period), .o_motor(o_motor), .o_enable(o_enable),
    .o_busy(o_busy), .o_done(o_done), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: each entry is {motor[2:0], enable, busy, done} for one cycle
  logic [5:0] exp_q[$];
  logic [2:0] last_motor = 3'b001;
  int         model_p = 0;
  int         n_vec = 0;
  int         n_fail = 0;
  int         en_cycles = 0;
  int         done_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [5:0] e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = {last_motor, 3'b000};
    last_motor = e[5:3];
    check("cycle_outputs", {26'd0, o_motor, o_enable, o_busy, o_done}, {26'd0, e});
    if (o_enable) en_cycles++;
    if (o_done) done_pulses++;
  end

  // Model: a move is a list of per-cycle outputs derived from the move rules.
  task automatic push_move(input bit d, input int n, input int per, input int stop_at);
    int  p;
    int  cyc;
    bit  halted;
    p = model_p;
    cyc = 0;
    halted = 0;
    exp_q.push_back({3'(p + 1), 3'b000});
    if (n != 0 && per != 0) begin
      for (int s = 0; s < n && !halted; s++) begin
        p = d ? (p + 1) % 4 : (p + 3) % 4;
        for (int c = 0; c < per && !halted; c++) begin
          cyc++;
          exp_q.push_back({3'(p + 1), 3'b110});
          if (cyc == stop_at) halted = 1;
        end
      end
    end
    exp_q.push_back({3'(p + 1), 3'b011});
    model_p = p;
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_p = 0;
    last_motor = 3'b001;
  endtask

  task automatic apply_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    model_reset();
    @(posedge clk); #3;
    rst = 1'b0;
  endtask

  // driver: one move; stop/extra start/reset at a given RUN cycle (0 = never)
  task automatic do_move(input bit d, input int n, input int per,
                         input int stop_at, input int extra_start_at, input int rst_at);
    int k;
    @(posedge clk); #1;
    en_cycles = 0;
    done_pulses = 0;
    start = 1'b1;
    dir = d;
    steps = 8'(n);
    period = 16'(per);
    push_move(d, n, per, stop_at);
    @(posedge clk); #1;
    start = 1'b0;
    dir = 1'($urandom_range(0, 1));
    steps = 8'($urandom_range(0, 255));
    period = 16'($urandom_range(0, 9));
    k = 1;
    while (k <= 400 && exp_q.size() != 0) begin
      if (k == rst_at) begin
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_mid_motor", {29'd0, o_motor}, 32'd1);
        check("rst_mid_flags", {29'd0, o_enable, o_busy, o_done}, 32'd0);
        break;
      end
      stop = (k == stop_at);
      start = (k == extra_start_at);
      @(posedge clk); #1;
      k++;
    end
    stop = 1'b0;
    start = 1'b0;
    check("move_drain", exp_q.size(), 0);
  endtask

  initial begin
    #3;
    check("reset_motor", {29'd0, o_motor}, 32'd1);
    check("reset_flags", {29'd0, o_enable, o_busy, o_done}, 32'd0);
    #19 rst = 1'b0;

    // forward 3 x 4 from P=0
    do_move(1'b1, 3, 4, 0, 0, 0);
    check("fwd_final_motor", {29'd0, o_motor}, 32'd4);
    check("fwd_enable_cycles", en_cycles, 12);
    check("fwd_done_pulses", done_pulses, 1);

    // reverse 5 x 1 with wrap from P=0
    apply_reset();
    do_move(1'b0, 5, 1, 0, 0, 0);
    check("rev_final_motor", {29'd0, o_motor}, 32'd4);
    check("rev_enable_cycles", en_cycles, 5);

    // zero-step and zero-period requests
    do_move(1'b1, 0, 7, 0, 0, 0);
    check("zero_steps_motor", {29'd0, o_motor}, 32'd4);
    check("zero_steps_enable", en_cycles, 0);
    check("zero_steps_done", done_pulses, 1);
    do_move(1'b0, 3, 0, 0, 0, 0);
    check("zero_period_motor", {29'd0, o_motor}, 32'd4);
    check("zero_period_enable", en_cycles, 0);

    // stop while idle is ignored
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("idle_stop_busy", {31'd0, o_busy}, 32'd0);

    // abort on 5th RUN cycle, extra start on 2nd ignored
    apply_reset();
    do_move(1'b1, 10, 3, 5, 2, 0);
    check("abort_motor", {29'd0, o_motor}, 32'd3);
    check("abort_enable_cycles", en_cycles, 5);
    check("abort_done_pulses", done_pulses, 1);

    // phase retained across moves
    do_move(1'b0, 2, 2, 0, 0, 0);
    check("retain_motor_a", {29'd0, o_motor}, 32'd1);
    do_move(1'b1, 6, 1, 0, 0, 0);
    check("retain_motor_b", {29'd0, o_motor}, 32'd3);

    // reset during RUN
    do_move(1'b1, 6, 2, 0, 0, 3);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_no_done", done_pulses, 0);
    check("rst_mid_idle_motor", {29'd0, o_motor}, 32'd1);

    // short forward move after the reset to confirm recovery
    do_move(1'b1, 1, 3, 0, 0, 0);
    check("recover_motor", {29'd0, o_motor}, 32'd2);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/motor_step_seq.md
MOTOR_STEP_SEQ -- requirements
Module: motor_step_seq

Interface
REQ-001 Parameter: STEP_W, 8, width of step-count input and internal remaining-step counter.
REQ-002 Parameter: PER_W, 16, width of step-period input and internal dwell timer.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 i_Clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 i_Rst  input  1  asynchronous active-high reset.
REQ-006 i_start  input  1  single-cycle move request, sampled only in IDLE.
REQ-007 i_stop  input  1  abort request, sampled only in RUN.
REQ-008 i_dir  input  1  direction latched at start: 1 = forward, 0 = reverse.
REQ-009 i_steps  input  STEP_W  number of phase advances, latched at start.
REQ-010 i_period  input  PER_W  dwell clock cycles per step, latched at start.
REQ-011 o_motor  output  3  phase code for the motor demux: 3'b001..3'b100.
REQ-012 o_enable  output  1  drive enable for the motor demux; high only in RUN.
REQ-013 o_busy  output  1  high whenever state is not IDLE.
REQ-014 o_done  output  1  one-cycle completion/abort pulse.

Function
REQ-015 The block SHALL hold a 2-bit phase register P; o_motor SHALL equal P+1 (zero-extended) in every state, including when o_enable is low.
REQ-016 Forward advance SHALL be P+1 mod 4 (001->010->011->100->001); reverse SHALL be P-1 mod 4 (001->100->011->010->001).
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-018 IDLE, i_start=1, i_steps!=0, i_period!=0: the block SHALL latch dir/steps/period, advance P once, set remaining=i_steps-1, clear timer, and enter RUN next cycle.
REQ-019 IDLE, i_start=1 with i_steps==0 or i_period==0: the block SHALL enter DONE next cycle without changing P or asserting o_enable.
REQ-020 RUN: the timer SHALL increment each cycle; at timer==period-1 with remaining>0 it SHALL advance P, decrement remaining and clear the timer.
REQ-021 RUN, timer==period-1 and remaining==0: the block SHALL enter DONE next cycle with no further advance.
REQ-022 A move of N steps SHALL spend exactly N*period cycles in RUN, each phase code presented with o_enable=1 for exactly period cycles.
REQ-023 RUN, i_stop=1: the block SHALL enter DONE next cycle, P unchanged; i_stop SHALL take priority over a same-cycle timer expiry.
REQ-024 DONE SHALL last exactly one cycle with o_done=1, o_enable=0, o_busy=1, then return to IDLE.
REQ-025 i_start outside IDLE and i_stop outside RUN SHALL be ignored.
REQ-026 P SHALL be retained across moves and aborts; only reset SHALL reinitialise it.
REQ-027 Changes on i_dir/i_steps/i_period after the start cycle SHALL have no effect on the move in progress.

Reset
REQ-028 On i_Rst=1, asynchronously: state=IDLE, P=0 (o_motor=3'b001), o_enable=0, o_busy=0, o_done=0, timer=0, remaining=0.
REQ-029 Reset asserted mid-RUN SHALL abort immediately without an o_done pulse.

Verification
REQ-030 Reset: assert i_Rst -> o_motor=001, o_enable=0, o_busy=0, o_done=0, independent of clock.
REQ-031 Forward move from P=0: start, dir=1, steps=3, period=4 -> o_motor 010/011/100 for 4 cycles each with o_enable=1, then one o_done cycle, IDLE with o_motor=100.
REQ-032 Reverse/wrap from P=0: start, dir=0, steps=5, period=1 -> o_motor 100,011,010,001,100 one cycle each, then o_done.
REQ-033 Zero move: start with steps=0 (period=7) -> o_done high the next cycle, o_enable never high, o_motor unchanged.
REQ-034 Abort: steps=10, period=3, i_stop on the 5th RUN cycle -> DONE next cycle, o_motor held at 011, extra i_start during RUN ignored.
REQ-035 Reset mid-move: i_Rst during RUN -> o_enable=0, o_motor=001 immediately, no o_done pulse.
